fir_out_capture: RTL

//  Downstream stage of the 600 kHz FIR filter. Samples the 16-bit filter output a fixed number of
//  12 MHz clocks after each sample strobe, which absorbs the filter's register latency. Each capture
//  is buffered in a small FIFO and drained through a valid/ready handshake to the consumer
//  (DAC/serializer/logger). Overflow is flagged and sticky.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/fir_out_capture.sv | 111 +++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the 600 kHz FIR filter datapath.
//   FIR_OUT_W  : width of the filter output word
//   SAMPLE_DIV : 12 MHz clocks per 600 kHz sample strobe
//   CAP_CNT_W  : width of the capture delay counter (covers 0..15)
//   cap_state_e: capture FSM states
package fir_pkg;

  localparam int FIR_OUT_W  = 16;
  localparam int SAMPLE_DIV = 20;
  localparam int CAP_CNT_W  = 4;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_WAIT = 1'b1
  } cap_state_e;

  // occupancy counter width for a FIFO of the given depth (0..depth inclusive)
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and word
//   pop        : consume head (ignored while empty)
//   dout, vld  : registered head word and its valid
//   full/empty : occupancy status, level = entries including the head
//   drop       : push refused this cycle (full and no pop)
module sync_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       din,
  input  logic                    pop,
  output logic [DATA_W-1:0]       dout,
  output logic                    vld,
  output logic                    full,
  output logic                    empty,
  output logic                    drop,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("sync_fifo: DEPTH must be a power of two in 2..64");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LVL_W-1:0]  level_nxt, remain;
  logic [DATA_W-1:0] head_nxt;
  logic              do_pop, do_wr;

  assign empty  = (level == '0);
  assign full   = (level == LVL_W'(DEPTH));
  assign do_pop = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_wr  = push & (~full | do_pop);
  assign drop   = push & full & ~do_pop;

  assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
  assign remain     = level - LVL_W'(do_pop);
  assign level_nxt  = remain + LVL_W'(do_wr);

  // Next head: if nothing older survives this cycle the incoming word
  // becomes the head; otherwise it is already sitting in memory.
  always_comb begin
    head_nxt = mem[rd_ptr_nxt];
    if (remain == '0) head_nxt = din;
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
      vld    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(do_wr);
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      vld    <= (level_nxt != '0);
      // hold the last word when going empty; head is stable while not popped
      if (level_nxt != '0) dout <= head_nxt;
    end
  end

endmodule

// File: rtl/fir_out_capture.sv
// Captures the FIR output CAP_DLY clocks after each sample strobe, queues the
// words in a FIFO and hands them to the consumer over valid/ready.
//   iClk_12MHz       : system clock
//   iRsn             : async active-low reset (release synchronised here)
//   iEnSample_600kHz : one-clock sample strobe shared with the FIR filter
//   iFirOut          : FIR output word, passed through bit-exact
//   iClrFlag         : synchronous clear of oOvf
//   iRdy             : consumer ready
//   oVld, oData      : registered FIFO head and its valid
//   oLevel           : FIFO occupancy 0..DEPTH
//   oOvf             : sticky, a capture was dropped on a full FIFO
module fir_out_capture
  import fir_pkg::*;
#(
  parameter int DATA_W  = FIR_OUT_W,
  parameter int DEPTH   = 8,
  parameter int CAP_DLY = 2
) (
  input  logic                   iClk_12MHz,
  input  logic                   iRsn,
  input  logic                   iEnSample_600kHz,
  input  logic [DATA_W-1:0]      iFirOut,
  input  logic                   iClrFlag,
  input  logic                   iRdy,
  output logic                   oVld,
  output logic [DATA_W-1:0]      oData,
  output logic [$clog2(DEPTH):0] oLevel,
  output logic                   oOvf
);

  if (CAP_DLY < 1 || CAP_DLY > 15) begin : g_chk_dly
    $error("fir_out_capture: CAP_DLY must be in 1..15");
  end

  localparam logic [CAP_CNT_W-1:0] RELOAD = CAP_CNT_W'(CAP_DLY - 1);

  // Reset asserts immediately, deasserts two edges after iRsn rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge iClk_12MHz or negedge iRsn) begin
    if (!iRsn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  cap_state_e           state, state_nxt;
  logic [CAP_CNT_W-1:0] cnt, cnt_nxt;
  logic                 cap;
  logic                 full, empty, drop;

  always_ff @(posedge iClk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= CAP_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The capture fires on the terminal count whether or not a new strobe
  // arrives; a strobe always (re)arms the counter, so an earlier pending
  // capture is abandoned but one completing this cycle is kept.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    case (state)
      CAP_IDLE: ;
      CAP_WAIT: begin
        if (cnt == '0) begin
          cap       = 1'b1;
          state_nxt = CAP_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = CAP_IDLE;
    endcase
    if (iEnSample_600kHz) begin
      state_nxt = CAP_WAIT;
      cnt_nxt   = RELOAD;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (iClk_12MHz),
    .rst_n (rst_n),
    .push  (cap),
    .din   (iFirOut),
    .pop   (oVld & iRdy),
    .dout  (oData),
    .vld   (oVld),
    .full  (full),
    .empty (empty),
    .drop  (drop),
    .level (oLevel)
  );

  // set beats clear when both happen in one cycle
  always_ff @(posedge iClk_12MHz or negedge rst_n) begin
    if (!rst_n)        oOvf <= 1'b0;
    else if (drop)     oOvf <= 1'b1;
    else if (iClrFlag) oOvf <= 1'b0;
  end

endmodule
